semafor_bit_memory_ncpu: RTL

//  N-port shared 1-bit memory with per-CPU one-bit mailbox semaphores for the multi-core logic unit.

---
 rtl/semafor_bit_memory_ncpu_pkg.sv | 40 ++++
 rtl/semafor_bit_memory_ncpu_slot.sv | 47 ++++
 rtl/semafor_bit_memory_ncpu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/semafor_bit_memory_ncpu_pkg.sv
// Shared definitions for the N-port semaphore bit memory: address-field
// positions, region/access encodings and their decode helpers.
package semafor_bit_memory_ncpu_pkg;

   localparam int PORT_AW     = 12;  // address bits per CPU port
   localparam int CONSUME_BIT = 7;   // semaphore read: 1 = consume, 0 = peek

   typedef enum logic [1:0] {
      REG_MEM,
      REG_SEM,
      REG_UNMAPPED
   } region_e;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_WRITE,
      ACC_READ
   } access_e;

   // A[11:10]=00 is the shared bit space; A[11]=1 with A[10:8]=0 is the semaphore space.
   function automatic region_e decode_region(input logic [PORT_AW-1:0] a);
      if (a[11:10] == 2'b00)
         return REG_MEM;
      else if (a[11] && (a[10:8] == 3'b000))
         return REG_SEM;
      else
         return REG_UNMAPPED;
   endfunction

   // WE wins over OE: a cycle with both strobes is a write.
   function automatic access_e decode_access(input logic we, input logic oe);
      if (we)
         return ACC_WRITE;
      else if (oe)
         return ACC_READ;
      else
         return ACC_IDLE;
   endfunction

endpackage

// File: rtl/semafor_bit_memory_ncpu_slot.sv
// One 1-bit mailbox {FULL, VAL}. The owner fills it when empty; any
// non-owner reader may drain it when the read carries the consume flag.
module semafor_slot #(
   parameter int N_CPU = 3
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             wr_req,
   input  logic             wr_val,
   input  logic [N_CPU-1:0] rd_req,
   input  logic [N_CPU-1:0] consume,
   output logic             wr_ok,
   output logic             rd_ok,
   output logic             val
);

   logic full_q, full_d;
   logic val_q, val_d;

   // Fill when empty; clear when full and any accepted reader consumes.
   always_comb begin
      full_d = full_q;
      val_d  = val_q;
      if (wr_req && !full_q) begin
         full_d = 1'b1;
         val_d  = wr_val;
      end else if (full_q && |(rd_req & consume)) begin
         full_d = 1'b0;
      end
   end

   // Mailbox state register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         full_q <= 1'b0;
         val_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         val_q  <= val_d;
      end
   end

   assign wr_ok = ~full_q;
   assign rd_ok = full_q;
   assign val   = val_q;

endmodule

// File: rtl/semafor_bit_memory_ncpu.sv
// N-port shared 1-bit memory with per-CPU one-bit mailbox semaphores.
// Optional per-port stall timeout: define SEMAFOR_TIMEOUT_EN to add the
// wait counters and the ERR port.
module semafor_bit_memory_ncpu
   import semafor_bit_memory_ncpu_pkg::*;
#(
   parameter int N_CPU     = 3,
   parameter int MEM_AW    = 10,
   parameter int SIDX_W    = 2,
   parameter int OWN_W     = 2,
   parameter int TIMEOUT_W = 8
) (
   input  logic                     CLK,
   input  logic                     CLR,
   input  logic [N_CPU*PORT_AW-1:0] A,
   input  logic [N_CPU-1:0]         DI,
   input  logic [N_CPU-1:0]         WE,
   input  logic [N_CPU-1:0]         OE,
   output logic [N_CPU-1:0]         DQ,
   output logic [N_CPU-1:0]         WT
`ifdef SEMAFOR_TIMEOUT_EN
   ,
   output logic [N_CPU-1:0]         ERR
`endif
);

   localparam int SEL_W    = SIDX_W + OWN_W;
   localparam int N_SEM    = N_CPU << SIDX_W;
   localparam int SEL_SPAN = 1 << SEL_W;

   if (N_CPU < 2 || N_CPU > 8 || N_CPU > (1 << OWN_W) || SEL_W > 7 ||
       MEM_AW < 1 || MEM_AW > 10 || TIMEOUT_W < 1) begin : g_bad_cfg
      $error("semafor_bit_memory_ncpu: illegal parameter combination");
   end

   region_e             rgn   [N_CPU];
   access_e             acc   [N_CPU];
   logic [SEL_W-1:0]    sel   [N_CPU];
   logic [MEM_AW-1:0]   maddr [N_CPU];
   logic [N_CPU-1:0]    mem_v, sem_v, own_v, cons_v, wr_v, rd_v, both_v;
   logic [N_CPU-1:0]    stall, fire;
   logic [SEL_SPAN-1:0] wr_ok_v, rd_ok_v, val_v;
   logic [N_SEM-1:0]    slot_wr_req, slot_wr_val;
   logic [N_CPU-1:0]    slot_rd_req [N_SEM];
   logic [N_CPU-1:0]    dq_q, dq_d;
   logic                mem_q [1 << MEM_AW];
   logic                unused_a;

   assign unused_a = ^A;

   for (genvar p = 0; p < N_CPU; p++) begin : g_port
      logic [PORT_AW-1:0] a;
      logic [OWN_W-1:0]   owner;
      assign a         = A[p*PORT_AW +: PORT_AW];
      assign owner     = a[SIDX_W +: OWN_W];
      assign rgn[p]    = decode_region(a);
      assign acc[p]    = decode_access(WE[p], OE[p]);
      assign sel[p]    = a[SEL_W-1:0];
      assign maddr[p]  = a[MEM_AW-1:0];
      assign mem_v[p]  = (rgn[p] == REG_MEM);
      assign sem_v[p]  = (rgn[p] == REG_SEM) && (int'(owner) < N_CPU);
      assign own_v[p]  = (int'(owner) == p);
      assign cons_v[p] = a[CONSUME_BIT];
      assign wr_v[p]   = (acc[p] == ACC_WRITE);
      assign rd_v[p]   = (acc[p] == ACC_READ);
      assign both_v[p] = WE[p] & OE[p];
      // Owner writes wait for an empty box, non-owner reads for a full one.
      assign stall[p]  = sem_v[p] &
                         ((wr_v[p] &  own_v[p] & ~wr_ok_v[sel[p]]) |
                          (rd_v[p] & ~own_v[p] & ~rd_ok_v[sel[p]]));
      assign WT[p]     = ~stall[p] | fire[p];
   end

   // Slot vectors are padded to the full select span; pad slots are never
   // selected because owner >= N_CPU decodes as unmapped.
   for (genvar s = 0; s < SEL_SPAN; s++) begin : g_slot
      if (s < N_SEM) begin : g_live
         semafor_slot #(.N_CPU(N_CPU)) u_slot (
            .CLK     (CLK),
            .CLR     (CLR),
            .wr_req  (slot_wr_req[s]),
            .wr_val  (slot_wr_val[s]),
            .rd_req  (slot_rd_req[s]),
            .consume (cons_v),
            .wr_ok   (wr_ok_v[s]),
            .rd_ok   (rd_ok_v[s]),
            .val     (val_v[s])
         );
      end else begin : g_pad
         assign wr_ok_v[s] = 1'b0;
         assign rd_ok_v[s] = 1'b0;
         assign val_v[s]   = 1'b0;
      end
   end

   // Route each port's semaphore request to its slot; timed-out accesses are dropped.
   always_comb begin
      slot_wr_req = '0;
      slot_wr_val = '0;
      for (int unsigned s = 0; s < N_SEM; s++) slot_rd_req[s] = '0;
      for (int unsigned p = 0; p < N_CPU; p++) begin
         if (sem_v[p] && !fire[p]) begin
            for (int unsigned s = 0; s < N_SEM; s++) begin
               if (sel[p] == SEL_W'(s)) begin
                  if (wr_v[p] && own_v[p]) begin
                     slot_wr_req[s] = 1'b1;
                     slot_wr_val[s] = DI[p];
                  end
                  if (rd_v[p] && !own_v[p]) slot_rd_req[s][p] = 1'b1;
               end
            end
         end
      end
   end

   // Shared bit space; ports applied high to low so the lowest index lands last and wins.
   always_ff @(posedge CLK) begin
      for (int unsigned k = 0; k < N_CPU; k++) begin
         if (mem_v[N_CPU-1-k] && wr_v[N_CPU-1-k])
            mem_q[maddr[N_CPU-1-k]] <= DI[N_CPU-1-k];
      end
   end

   // Read data selection; a stalled non-owner read and idle cycles hold DQ.
   always_comb begin
      dq_d = dq_q;
      for (int unsigned p = 0; p < N_CPU; p++) begin
         if (fire[p] || both_v[p])
            dq_d[p] = 1'b0;
         else if (rd_v[p]) begin
            if (mem_v[p])
               dq_d[p] = mem_q[maddr[p]];
            else if (!sem_v[p])
               dq_d[p] = 1'b0;
            else if (own_v[p])
               dq_d[p] = rd_ok_v[sel[p]];
            else if (rd_ok_v[sel[p]])
               dq_d[p] = val_v[sel[p]];
         end
      end
   end

   // Registered read data.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) dq_q <= '0;
      else      dq_q <= dq_d;
   end

   assign DQ = dq_q;

`ifdef SEMAFOR_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt_q [N_CPU];
   logic [TIMEOUT_W-1:0] cnt_d [N_CPU];
   logic [N_CPU-1:0]     err_q;

   // Count stalled cycles; an all-ones count forces WT for one cycle.
   always_comb begin
      for (int unsigned p = 0; p < N_CPU; p++) begin
         fire[p]  = (cnt_q[p] == '1);
         cnt_d[p] = (stall[p] && !fire[p]) ? cnt_q[p] + TIMEOUT_W'(1) : '0;
      end
   end

   // Wait counters and one-cycle timeout flag.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int unsigned p = 0; p < N_CPU; p++) cnt_q[p] <= '0;
         err_q <= '0;
      end else begin
         for (int unsigned p = 0; p < N_CPU; p++) cnt_q[p] <= cnt_d[p];
         err_q <= fire;
      end
   end

   assign ERR = err_q;
`else
   assign fire = '0;
`endif

endmodule
